// File: rtl/softmax_pkg.sv
// softmax_pkg: shared state enum, default sizes and saturation helper for softmax_pack
package softmax_pkg;
  typedef enum logic {COLLECT, DRAIN} state_e;
  localparam int DEF_DW = 32;
  localparam int DEF_N = 32;
  localparam int DEF_OUT_BITS = 8;
  localparam int DEF_LANES = 4;
  localparam int WORD_W = DEF_LANES * DEF_OUT_BITS;
  localparam int IDX_W = $clog2(DEF_N);
  // Clamp a signed value into [0, 2^ob-1]; callers cast the result down to ob bits.
  function automatic logic [63:0] sat_u(input logic signed [63:0] v, input int ob);
    logic signed [63:0] mx;
    mx = (64'sd1 <<< ob) - 64'sd1;
    return (v < 0) ? 64'd0 : (v > mx) ? mx : v;
  endfunction
endpackage

// File: rtl/softmax_pack_buf.sv
// pack_buf: 2-entry FIFO whose head entry is always a register (slot 0)
module pack_buf import softmax_pkg::*; #(
  parameter int WW = WORD_W,
  parameter int AW = IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [WW-1:0] data_i,
  input  logic          last_i,
  input  logic [AW-1:0] arg_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [WW-1:0] data_o,
  output logic          last_o,
  output logic [AW-1:0] arg_o
);
  localparam int EW = WW + 1 + AW;
  logic [EW-1:0] s0_q, s0_d, s1_q, s1_d, din;
  logic [1:0]    cnt_q, cnt_d;
  assign din = {data_i, last_i, arg_i};
  assign {data_o, last_o, arg_o} = s0_q;
  assign full_o = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  // Slot 0 is the head; a pop shifts slot 1 forward, a push fills the first free slot.
  always_comb begin
    cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
    s0_d = (pop_i && full_o) ? s1_q :
           (push_i && (empty_o || (pop_i && cnt_q == 2'd1))) ? din : s0_q;
    s1_d = (push_i && ((cnt_q == 2'd1 && !pop_i) || (full_o && pop_i))) ? din : s1_q;
  end
  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
    end
  end
endmodule

// File: rtl/softmax_pack.sv
// softmax_pack: saturate softmax outputs, pack LANES per word, report row argmax
module softmax_pack import softmax_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int N = DEF_N,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int LANES = DEF_LANES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [DW-1:0]      y_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_BITS-1:0] out_data,
  output logic                      out_last,
  output logic [$clog2(N)-1:0]      argmax,
  output logic                      overflow_err
);
  localparam int WW = LANES * OUT_BITS;
  localparam int IW = $clog2(N);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  state_e              state_q, state_d;
  logic [IW-1:0]       elem_q, elem_d, max_i_q, max_i_d, cur_i;
  logic [LW-1:0]       lane_q, lane_d;
  logic [WW-1:0]       lanes_q, lanes_d, word;
  logic [OUT_BITS-1:0] max_v_q, max_v_d, sat_v;
  logic                err_q, err_d;
  logic                row_end, push_due, full, empty, accept, push, pop, gt, head_last;
  logic signed [63:0]  y_ext;
  assign y_ext = 64'(y_in);
  assign sat_v = OUT_BITS'(sat_u(y_ext, OUT_BITS));
  assign row_end = elem_q == IW'(N - 1);
  assign push_due = lane_q == LW'(LANES - 1) || row_end;
  assign accept = state_q == COLLECT && in_valid && !(push_due && full);
  assign push = accept && push_due;
  assign pop = !empty && out_ready;
  assign gt = sat_v > max_v_q;
  assign cur_i = gt ? elem_q : max_i_q;
  assign word = lanes_q | (WW'(sat_v) << (OUT_BITS * int'(lane_q)));
  assign out_valid = !empty;
  assign out_last = head_last;
  assign overflow_err = err_q;
  pack_buf #(.WW(WW), .AW(IW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (word),
    .last_i  (row_end),
    .arg_i   (cur_i),
    .full_o  (full),
    .empty_o (empty),
    .data_o  (out_data),
    .last_o  (head_last),
    .arg_o   (argmax)
  );
  // Accepted elements fill lanes and track the max; a word push clears the lanes, a row-end push restarts the row.
  always_comb begin
    err_d   = err_q | (in_valid && !accept);
    lanes_d = accept ? (push ? '0 : word) : lanes_q;
    lane_d  = accept ? (push ? '0 : lane_q + 1'b1) : lane_q;
    elem_d  = accept ? (push && row_end ? '0 : elem_q + 1'b1) : elem_q;
    max_v_d = accept ? (push && row_end ? '0 : (gt ? sat_v : max_v_q)) : max_v_q;
    max_i_d = accept ? (push && row_end ? '0 : cur_i) : max_i_q;
    state_d = (state_q == COLLECT && push && row_end) ? DRAIN :
              (state_q == DRAIN && pop && head_last) ? COLLECT : state_q;
  end
  // State, counters, lane register, running max and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      elem_q  <= '0;
      lane_q  <= '0;
      lanes_q <= '0;
      max_v_q <= '0;
      max_i_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      lane_q  <= lane_d;
      lanes_q <= lanes_d;
      max_v_q <= max_v_d;
      max_i_q <= max_i_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/softmax_pack.md
# softmax_pack

Downstream stage of `softmax`. Consumes its per-element `out_valid`/`y_out` stream, saturates each probability to OUT_BITS unsigned, and packs LANES results per output word. Words go out on a ready/valid interface, with row-end marking and argmax reporting. Upstream has no backpressure, so the block buffers two words and flags any input it must drop.

## Interface
- DW, 32: width of incoming `y_in`
- N, 32: elements per row (softmax vector length)
- OUT_BITS, 8: bits per packed probability
- LANES, 4: probabilities per output word; lane 0 = LSBs, holds lowest element index
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  `y_in` valid this cycle (driven by softmax `out_valid`)
- y_in  in  DW signed  softmax output element
- out_valid  out  1  `out_data` holds a word
- out_ready  in  1  downstream accepts word when high with `out_valid`
- out_data  out  LANES*OUT_BITS  packed probabilities
- out_last  out  1  qualifies the final word of a row
- argmax  out  $clog2(N)  index of the largest element in the row; valid when `out_last`
- overflow_err  out  1  sticky; set when an input is dropped; cleared only by reset

## Operation
- Saturation: `y_in < 0` → 0. `y_in > 2^OUT_BITS-1` → 2^OUT_BITS-1. Otherwise truncate to OUT_BITS bits. A value of 256 at OUT_BITS=8 occurs for a one-hot row and must give 255.
- Counters: `elem_idx` 0..N-1 and `lane_idx` 0..LANES-1, both reset to 0.
- FSM:
  - COLLECT: accept each `in_valid` element into the lane register at `lane_idx`. A word is pushed to the 2-entry buffer when `lane_idx == LANES-1` or `elem_idx == N-1`. A partial final word zero-fills unused lanes. The word pushed for `elem_idx == N-1` carries last=1 and the current argmax. After that push: go to DRAIN, counters → 0, lane register → 0.
  - DRAIN: `in_valid` inputs are dropped and set `overflow_err`. Return to COLLECT in the cycle after the last=1 word handshakes.
- Argmax: running maximum over saturated values. Strictly-greater compare, so ties keep the lower index. Reset to value 0 / index 0 at each row start.
- Buffer full (2 words held) in COLLECT when a push is due: drop the incoming element, set `overflow_err`, do not advance counters.
- Buffer push and pop in the same cycle are both allowed at any occupancy ≥1.

## Timing
- Reset (`rst` low, async): `out_valid`=0, `out_data`=0, `out_last`=0, `argmax`=0, `overflow_err`=0. FSM → COLLECT; counters, lane register and buffer cleared. Reset mid-row discards partial data with no output.
- Latency: the element completing a word is accepted at cycle t. The word is on `out_data` with `out_valid`=1 at t+1 if the buffer was empty.
- `out_data`/`out_last`/`argmax` are registered and held stable while `out_valid && !out_ready`.
- Throughput: one input per cycle sustained; one output word per cycle when `out_ready`=1.
- `out_valid` never depends combinationally on `out_ready`.

## Structure
- Package `softmax_pkg`: FSM state enum (COLLECT, DRAIN), `sat_u` function (signed DW → unsigned OUT_BITS), localparams WORD_W = LANES*OUT_BITS and IDX_W = $clog2(N).
- One sub-module, `pack_buf`: 2-entry registered FIFO with fields {data, last, argmax}. It has push/pop/full/empty and a registered head.
- Top holds the FSM, counters, lane register, saturation and argmax.

## Test plan
Bench defaults N=8, LANES=4, OUT_BITS=8 unless stated.
- **Basic pack:** inputs 1..8 back-to-back, `out_ready`=1 → words 0x04030201 then 0x08070605 with last=1, argmax=7, `overflow_err`=0.
- **Saturation and ties:** inputs {-5, 300, 256, 9, 255, 0, 0, 0} → words 0x09FFFF00, 0x000000FF. argmax=1 (tie with idx 2 and idx 4 keeps the lowest).
- **Partial word:** N=6, inputs 10..15 → second word 0x00000F0E with last=1, argmax=5.
- **Backpressure:**
  - `out_ready`=0 for 10 cycles while a row of 8 streams → both words held stable, no `overflow_err`.
  - A further row started during DRAIN → `overflow_err`=1, dropped inputs produce no output.
- **Async reset mid-row:** drop `rst` after 3 inputs → all outputs 0 immediately. A new row after release packs from lane 0 with argmax restarted.
- **Simultaneous push/pop:** buffer holds 1 word, `out_ready`=1 in the same cycle the next word completes → no drop, correct order, `out_valid` stays high.
